// File: rtl/control_register_bank_if.sv
// control_register_bank_if
//   Command and response streams of the CPU-side register bank.
//   cmd_in/cmd_in_stb/cmd_in_ack : 32-bit command words (header, then data)
//   rsp_out/rsp_out_stb/rsp_out_ack : 32-bit read data back to the CPU
//   master modport: the CPU side (main_0); slave modport: the register bank.
interface control_register_bank_if;
  logic [31:0] cmd_in;
  logic        cmd_in_stb;
  logic        cmd_in_ack;
  logic [31:0] rsp_out;
  logic        rsp_out_stb;
  logic        rsp_out_ack;

  modport master (
    output cmd_in, cmd_in_stb, rsp_out_ack,
    input  cmd_in_ack, rsp_out, rsp_out_stb
  );

  modport slave (
    input  cmd_in, cmd_in_stb, rsp_out_ack,
    output cmd_in_ack, rsp_out, rsp_out_stb
  );
endinterface

// File: rtl/control_register_bank.sv
// control_register_bank
//   NUM_REGS-entry register file in the clk_50 CPU domain, written and read
//   in bursts over a stb/ack command stream and a stb/ack response stream.
//   Ports:
//     clk, rst    : clock, synchronous active-high reset
//     bus         : command/response streams (control_register_bank_if.slave)
//     regs_out    : active register contents, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//     reg_update  : 1-cycle pulse when active reg i takes a new value
//     error_out   : sticky, set by any access to an address >= NUM_REGS
//     pps_in      : async GPS 1PPS, only when COMMIT_ON_PPS_EN is defined
//   Build option COMMIT_ON_PPS_EN: writes land in shadow registers and are
//   copied to the active set on the next synchronised rising edge of pps_in.
module control_register_bank #(
  parameter int          NUM_REGS    = 8,
  parameter int          ADDR_WIDTH  = 3,
  parameter int          DATA_WIDTH  = 32,
  parameter logic [31:0] RESET_VALUE = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  control_register_bank_if.slave         bus,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
  output logic [NUM_REGS-1:0]            reg_update,
  output logic                           error_out
`ifdef COMMIT_ON_PPS_EN
  ,
  input  logic                           pps_in
`endif
);
  localparam logic [DATA_WIDTH-1:0] RV = RESET_VALUE[DATA_WIDTH-1:0];

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q, rd_addr;
  logic [7:0]            cnt_q;       // words remaining after the current one
  logic                  hdr_xfer, wr_xfer, rsp_xfer, rd_load;
  logic [NUM_REGS-1:0]   wr_match, rd_match;
  logic [DATA_WIDTH-1:0] act_q  [NUM_REGS];
  logic [DATA_WIDTH-1:0] rd_src [NUM_REGS];
  logic [DATA_WIDTH-1:0] wr_data;
  logic [31:0]           rd_data;

  assign wr_data = bus.cmd_in[DATA_WIDTH-1:0];

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state and strobes. rd_load fires when a new response word must
  // be fetched: on a read header, and on every ack except the last.
  always_comb begin
    state_d        = state_q;
    bus.cmd_in_ack = 1'b0;
    hdr_xfer       = 1'b0;
    wr_xfer        = 1'b0;
    rsp_xfer       = 1'b0;
    rd_load        = 1'b0;
    rd_addr        = addr_q;
    case (state_q)
      IDLE: begin
        bus.cmd_in_ack = 1'b1;
        rd_addr        = bus.cmd_in[ADDR_WIDTH-1:0];
        if (bus.cmd_in_stb) begin
          hdr_xfer = 1'b1;
          if (bus.cmd_in[31]) state_d = WRITE;
          else begin
            state_d = READ;
            rd_load = 1'b1;
          end
        end
      end
      WRITE: begin
        bus.cmd_in_ack = 1'b1;
        if (bus.cmd_in_stb) begin
          wr_xfer = 1'b1;
          if (cnt_q == 8'd0) state_d = IDLE;
        end
      end
      READ: begin
        if (bus.rsp_out_stb && bus.rsp_out_ack) begin
          rsp_xfer = 1'b1;
          if (cnt_q == 8'd0) state_d = IDLE;
          else               rd_load = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Address decode; addresses >= NUM_REGS match nothing.
  always_comb begin
    wr_match = '0;
    rd_match = '0;
    rd_data  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_match[i] = (addr_q  == ADDR_WIDTH'(i));
      rd_match[i] = (rd_addr == ADDR_WIDTH'(i));
      if (rd_match[i]) rd_data = 32'(rd_src[i]);
    end
  end

  // Burst bookkeeping, response register and error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q          <= '0;
      cnt_q           <= '0;
      bus.rsp_out     <= '0;
      bus.rsp_out_stb <= 1'b0;
      error_out       <= 1'b0;
    end else begin
      if (hdr_xfer) begin
        cnt_q  <= bus.cmd_in[23:16];
        // a read header already fetches its first word, so point past it
        addr_q <= bus.cmd_in[31] ? bus.cmd_in[ADDR_WIDTH-1:0]
                                 : bus.cmd_in[ADDR_WIDTH-1:0] + ADDR_WIDTH'(1);
      end else if (wr_xfer || rd_load) begin
        addr_q <= addr_q + ADDR_WIDTH'(1);
        cnt_q  <= cnt_q - 8'd1;
      end
      if (rd_load) begin
        bus.rsp_out     <= rd_data;
        bus.rsp_out_stb <= 1'b1;
      end else if (rsp_xfer) begin
        bus.rsp_out_stb <= 1'b0;
      end
      if ((wr_xfer && !(|wr_match)) || (rd_load && !(|rd_match)))
        error_out <= 1'b1;
    end
  end

`ifdef COMMIT_ON_PPS_EN
  logic [DATA_WIDTH-1:0] shd_q [NUM_REGS];
  logic [NUM_REGS-1:0]   pend_q;
  logic [2:0]            pps_q;       // [1:0] synchroniser, [2] edge-detect history
  logic                  commit;

  assign commit = pps_q[1] & ~pps_q[2];

  // Commit copies the pre-edge shadow; a write on the commit cycle therefore
  // stays pending for the next PPS.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        act_q[i] <= RV;
        shd_q[i] <= RV;
      end
      pend_q     <= '0;
      pps_q      <= '0;
      reg_update <= '0;
    end else begin
      pps_q      <= {pps_q[1:0], pps_in};
      reg_update <= commit ? pend_q : '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (commit && pend_q[i]) act_q[i] <= shd_q[i];
        if (wr_xfer && wr_match[i]) begin
          shd_q[i]  <= wr_data;
          pend_q[i] <= 1'b1;
        end else if (commit) begin
          pend_q[i] <= 1'b0;
        end
      end
    end
  end

  always_comb rd_src = shd_q;
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) act_q[i] <= RV;
      reg_update <= '0;
    end else begin
      reg_update <= wr_xfer ? wr_match : '0;
      for (int i = 0; i < NUM_REGS; i++)
        if (wr_xfer && wr_match[i]) act_q[i] <= wr_data;
    end
  end

  always_comb rd_src = act_q;
`endif

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign regs_out[g*DATA_WIDTH +: DATA_WIDTH] = act_q[g];
  end
endmodule

// File: tb/tb_control_register_bank.sv
module tb_control_register_bank;
  localparam int NR = 8;
  localparam int NB = 6;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  control_register_bank_if ifa();
  control_register_bank_if ifb();

  logic [NR*DW-1:0] regs_a;
  logic [NB*DW-1:0] regs_b;
  logic [NR-1:0]    upd_a;
  logic [NB-1:0]    upd_b;
  logic             err_a, err_b;
`ifdef COMMIT_ON_PPS_EN
  logic             pps = 1'b0;
`endif

  // Both instances see the same command stream; ifb's bank has only 6 regs.
  control_register_bank #(.NUM_REGS(NR), .ADDR_WIDTH(3), .DATA_WIDTH(DW), .RESET_VALUE(32'h0)) dut (
    .clk(clk), .rst(rst), .bus(ifa), .regs_out(regs_a), .reg_update(upd_a), .error_out(err_a)
`ifdef COMMIT_ON_PPS_EN
    , .pps_in(pps)
`endif
  );

  control_register_bank #(.NUM_REGS(NB), .ADDR_WIDTH(3), .DATA_WIDTH(DW), .RESET_VALUE(32'h0)) dut6 (
    .clk(clk), .rst(rst), .bus(ifb), .regs_out(regs_b), .reg_update(upd_b), .error_out(err_b)
`ifdef COMMIT_ON_PPS_EN
    , .pps_in(pps)
`endif
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] rd_a [16];
  logic [31:0] rd_b [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [31:0] w, input logic s);
    ifa.cmd_in = w; ifa.cmd_in_stb = s;
    ifb.cmd_in = w; ifb.cmd_in_stb = s;
  endtask

  task automatic set_ack(input logic a);
    ifa.rsp_out_ack = a;
    ifb.rsp_out_ack = a;
  endtask

  // Present one word and hold it until the transfer edge has passed.
  task automatic send(input logic [31:0] w);
    int t = 0;
    drv(w, 1'b1);
    while (!ifa.cmd_in_ack && t < 20) begin tick(); t++; end
    if (!ifa.cmd_in_ack) begin
      checks++; failures++;
      $display("FAIL cmd_ack_timeout got=0 expected=1");
    end
    tick();
    drv(32'h0, 1'b0);
  endtask

  // Read burst with ack held high; words from both instances are captured.
  task automatic read_burst(input logic [31:0] hdr, input int n);
    int t;
    set_ack(1'b1);
    send(hdr);
    chk("rd_first_word_latency", 32'(ifa.rsp_out_stb), 32'd1);
    for (int k = 0; k < n; k++) begin
      t = 0;
      while (!ifa.rsp_out_stb && t < 20) begin tick(); t++; end
      rd_a[k] = ifa.rsp_out;
      rd_b[k] = ifb.rsp_out;
      tick();
    end
    chk("rd_end_stb", 32'(ifa.rsp_out_stb), 32'd0);
    chk("rd_end_idle_ack", 32'(ifa.cmd_in_ack), 32'd1);
    set_ack(1'b0);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] hdr;
    int          n;
    logic [31:0] d [3];   // write data, or expected read data
  } vec_t;

  vec_t tbl [6];

  initial begin
    int a;
    tbl[0] = '{1'b1, 32'h8001_0002, 2, '{32'h11, 32'h22, 32'h0}};
    tbl[1] = '{1'b1, 32'h8001_0007, 2, '{32'hA, 32'hB, 32'h0}};
    tbl[2] = '{1'b0, 32'h0001_0007, 2, '{32'hA, 32'hB, 32'h0}};
    tbl[3] = '{1'b0, 32'h0001_0002, 2, '{32'h11, 32'h22, 32'h0}};
    tbl[4] = '{1'b1, 32'h8000_0005, 1, '{32'hDEAD_BEEF, 32'h0, 32'h0}};
    tbl[5] = '{1'b0, 32'h0002_0004, 3, '{32'h0, 32'hDEAD_BEEF, 32'h77}};

    drv(32'h0, 1'b0);
    set_ack(1'b0);
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    chk("rst_regs_a", 32'(|regs_a), 32'd0);
    chk("rst_regs_b", 32'(|regs_b), 32'd0);
    chk("rst_cmd_ack", 32'(ifa.cmd_in_ack), 32'd1);
    chk("rst_rsp_stb", 32'(ifa.rsp_out_stb), 32'd0);
    chk("rst_rsp_out", ifa.rsp_out, 32'd0);
    chk("rst_error_a", 32'(err_a), 32'd0);
    chk("rst_error_b", 32'(err_b), 32'd0);
    chk("rst_update", 32'(upd_a), 32'd0);

    // Out-of-range access on the 6-register bank
    send(32'h8000_0006);
    chk("oor_err_after_hdr", 32'(err_b), 32'd0);
    send(32'h77);
    chk("oor_wr_err", 32'(err_b), 32'd1);
    chk("oor_wr_no_change", 32'(|regs_b), 32'd0);
    chk("oor_wr_no_update", 32'(upd_b), 32'd0);
    chk("inrange_reg6", regs_a[6*DW +: DW], 32'h77);
    chk("inrange_no_err", 32'(err_a), 32'd0);
    tick();
    read_burst(32'h0000_0007, 1);
    chk("oor_rd_zero", rd_b[0], 32'h0);
    chk("oor_rd_err_sticky", 32'(err_b), 32'd1);
    chk("inrange_rd7", rd_a[0], 32'h0);

    // Table-driven bursts
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].wr) begin
        send(tbl[i].hdr);
        for (int k = 0; k < tbl[i].n; k++) begin
          a = (int'(tbl[i].hdr[2:0]) + k) % NR;
          send(tbl[i].d[k]);
          chk($sformatf("v%0d_w%0d_update", i, k), 32'(upd_a), 32'd1 << a);
          chk($sformatf("v%0d_w%0d_reg%0d", i, k, a), regs_a[a*DW +: DW], tbl[i].d[k]);
        end
        tick();
        chk($sformatf("v%0d_update_cleared", i), 32'(upd_a), 32'd0);
      end else begin
        read_burst(tbl[i].hdr, tbl[i].n);
        for (int k = 0; k < tbl[i].n; k++)
          chk($sformatf("v%0d_r%0d", i, k), rd_a[k], tbl[i].d[k]);
      end
    end

    // Stalled read: word held while ack is low, then 1 word per cycle
    set_ack(1'b0);
    send(32'h0002_0000);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("stall%0d_stb", c), 32'(ifa.rsp_out_stb), 32'd1);
      chk($sformatf("stall%0d_data", c), ifa.rsp_out, 32'hB);
      tick();
    end
    set_ack(1'b1);
    chk("b2b0", ifa.rsp_out, 32'hB);
    tick();
    chk("b2b1_stb", 32'(ifa.rsp_out_stb), 32'd1);
    chk("b2b1", ifa.rsp_out, 32'h0);
    tick();
    chk("b2b2_stb", 32'(ifa.rsp_out_stb), 32'd1);
    chk("b2b2", ifa.rsp_out, 32'h11);
    tick();
    chk("b2b_end_stb", 32'(ifa.rsp_out_stb), 32'd0);
    set_ack(1'b0);

    // Reset in the middle of a 3-word write burst
    send(32'h8002_0001);
    send(32'h55);
    chk("mid_first_word", regs_a[1*DW +: DW], 32'h55);
    rst = 1'b1;
    tick();
    chk("mid_rst_no_update", 32'(upd_a), 32'd0);
    rst = 1'b0;
    chk("mid_rst_regs", 32'(|regs_a), 32'd0);
    chk("mid_rst_ack", 32'(ifa.cmd_in_ack), 32'd1);
    chk("mid_rst_err_clr", 32'(err_b), 32'd0);
    // A read header must be taken as a header, not as the next write word
    read_burst(32'h0000_0001, 1);
    chk("mid_rst_read_reg1", rd_a[0], 32'h0);
    chk("mid_rst_regs_after", 32'(|regs_a), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
